// File: rtl/irq_request_ctrl.sv
// Interrupt request initiator: synchronises, debounces and edge-detects button lines,
// then presents one prioritised, held-stable request to the CPU until it is acknowledged.
module irq_request_ctrl #(
  parameter int N_IRQ           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int ID_WIDTH        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IRQ-1:0]    BTN,
  input  logic                ack,
  input  logic [ID_WIDTH-1:0] ack_id,
  output logic                irq_req,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [N_IRQ-1:0]    IRW
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0]  ID_NONE  = {ID_WIDTH{1'b0}};
  localparam logic [N_IRQ-1:0]     VEC_ZERO = {N_IRQ{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [N_IRQ-1:0]     sync1_q, sync1_d;
  logic [N_IRQ-1:0]     sync2_q, sync2_d;
  logic [N_IRQ-1:0]     db_q, db_d;
  logic [N_IRQ-1:0]     db_dly_q, db_dly_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_IRQ];
  logic [CNT_WIDTH-1:0] cnt_d [N_IRQ];
  logic [N_IRQ-1:0]     pend_q, pend_d;
  state_e               state_q, state_d;
  logic                 irq_req_q, irq_req_d;
  logic [ID_WIDTH-1:0]  irq_id_q, irq_id_d;

  logic [N_IRQ-1:0]     rise_s;
  logic [N_IRQ-1:0]     clr_s;
  logic [ID_WIDTH-1:0]  top_id_s;
  logic                 ack_hit_s;

  always_comb begin
    sync1_d  = BTN;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
  end

  // A line's debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_IRQ; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
  end

  always_comb begin
    top_id_s = ID_NONE;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pend_q[i]) begin
        top_id_s = ID_WIDTH'(i + 1);
      end else begin
        top_id_s = top_id_s;
      end
    end
  end

  // A same-cycle rising edge wins over the clear, so a re-press during the ack is not lost.
  always_comb begin
    rise_s    = db_q & ~db_dly_q;
    ack_hit_s = (state_q == ST_REQ) && ack && (ack_id == irq_id_q);
    for (int i = 0; i < N_IRQ; i++) begin
      clr_s[i] = ack_hit_s && (irq_id_q == ID_WIDTH'(i + 1));
    end
    pend_d = (pend_q & ~clr_s) | rise_s;
  end

  always_comb begin
    state_d   = state_q;
    irq_req_d = irq_req_q;
    irq_id_d  = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != VEC_ZERO) begin
          state_d   = ST_REQ;
          irq_req_d = 1'b1;
          irq_id_d  = top_id_s;
        end else begin
          irq_req_d = 1'b0;
          irq_id_d  = ID_NONE;
        end
      end
      ST_REQ: begin
        if (ack_hit_s) begin
          state_d   = ST_GAP;
          irq_req_d = 1'b0;
          irq_id_d  = ID_NONE;
        end else begin
          irq_req_d = 1'b1;
          irq_id_d  = irq_id_q;
        end
      end
      ST_GAP: begin
        state_d   = ST_IDLE;
        irq_req_d = 1'b0;
        irq_id_d  = ID_NONE;
      end
      default: begin
        state_d   = ST_IDLE;
        irq_req_d = 1'b0;
        irq_id_d  = ID_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= VEC_ZERO;
      sync2_q   <= VEC_ZERO;
      db_q      <= VEC_ZERO;
      db_dly_q  <= VEC_ZERO;
      pend_q    <= VEC_ZERO;
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= ID_NONE;
      for (int i = 0; i < N_IRQ; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
      for (int i = 0; i < N_IRQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign IRW     = pend_q;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Self-checking bench for irq_request_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model of the request controller.
module tb_irq_request_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] BTN;
  logic       ack;
  logic [1:0] ack_id;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [2:0] IRW;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_request_ctrl #(.N_IRQ(3), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .BTN(BTN), .ack(ack), .ack_id(ack_id),
    .irq_req(irq_req), .irq_id(irq_id), .IRW(IRW)
  );

  // Behavioural model: button history, run length of disagreeing samples, pending set, handshake phase.
  logic [2:0] m_s1, m_s2, m_db, m_dbp, m_pend;
  int         m_run [3];
  int         m_st;
  logic [1:0] m_id;
  logic       m_req;

  task automatic tick();
    logic [2:0] n_s1, n_s2, n_db, n_dbp, n_pend, clr;
    int         n_run [3];
    int         n_st;
    logic [1:0] n_id;
    bit         acc;
    if (rst) begin
      n_s1 = 3'b000; n_s2 = 3'b000; n_db = 3'b000; n_dbp = 3'b000; n_pend = 3'b000;
      for (int i = 0; i < 3; i++) n_run[i] = 0;
      n_st = 0; n_id = 2'd0;
    end else begin
      n_s1 = BTN; n_s2 = m_s1; n_db = m_db; n_dbp = m_db;
      for (int i = 0; i < 3; i++) begin
        n_run[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
        if (n_run[i] == D) begin
          n_db[i]  = ~m_db[i];
          n_run[i] = 0;
        end
      end
      acc = (m_st == 1) && ack && (ack_id == m_id);
      clr = 3'b000;
      if (acc) clr[int'(m_id) - 1] = 1'b1;
      n_pend = (m_pend & ~clr) | (m_db & ~m_dbp);
      n_st = m_st; n_id = m_id;
      if (m_st == 0) begin
        if (m_pend != 3'b000) begin
          n_st = 1;
          for (int i = 0; i < 3; i++) if (m_pend[i]) n_id = 2'(i + 1);
        end
      end else if (m_st == 1) begin
        if (acc) begin n_st = 2; n_id = 2'd0; end
      end else begin
        n_st = 0; n_id = 2'd0;
      end
    end
    @(posedge clk);
    #1;
    m_s1 = n_s1; m_s2 = n_s2; m_db = n_db; m_dbp = n_dbp; m_pend = n_pend;
    m_run = n_run; m_st = n_st; m_id = n_id; m_req = (n_st == 1);
  endtask

  task automatic drain();
    int quiet = 0;
    BTN = 3'b000;
    for (int c = 0; c < 300 && quiet < 12; c++) begin
      ack = irq_req; ack_id = irq_id;
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL drain_model: got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
      if (!irq_req && IRW == 3'b000) quiet++; else quiet = 0;
    end
    ack = 1'b0;
    checks++;
    if (quiet < 12) begin
      errors++;
      $display("FAIL drain_timeout: got %0d quiet cycles, want 12", quiet);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; BTN = 3'b111; ack = 1'b0; ack_id = 2'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== 6'b000000) begin
        errors++;
        $display("FAIL reset_hold: got req=%0b id=%0d irw=%b, want all 0", irq_req, irq_id, IRW);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL reset_model: got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
      if (n == 6 || n == 7) begin
        checks++;
        if (IRW !== ((n == 7) ? 3'b111 : 3'b000)) begin
          errors++;
          $display("FAIL reset_held_irw: tick %0d got %b, want %b", n, IRW, (n == 7) ? 3'b111 : 3'b000);
        end
      end
      if (n == 8) begin
        checks++;
        if (irq_req !== 1'b1 || irq_id !== 2'd3) begin
          errors++;
          $display("FAIL reset_held_req: got req=%0b id=%0d, want req=1 id=3", irq_req, irq_id);
        end
      end
    end
    drain();
  endtask

  task automatic test_single_press();
    BTN = 3'b001;
    for (int n = 1; n <= 16; n++) begin
      ack = (n == 11); ack_id = 2'd1;
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL single_model: got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
      checks++;
      if ((n == 6 && (IRW !== 3'b000 || irq_req !== 1'b0)) ||
          (n == 7 && (IRW !== 3'b001 || irq_req !== 1'b0)) ||
          ((n >= 8 && n <= 10) && (IRW !== 3'b001 || irq_req !== 1'b1 || irq_id !== 2'd1)) ||
          (n >= 11 && (IRW !== 3'b000 || irq_req !== 1'b0 || irq_id !== 2'd0))) begin
        errors++;
        $display("FAIL single_timing: tick %0d got req=%0b id=%0d irw=%b", n, irq_req, irq_id, IRW);
      end
    end
    ack = 1'b0;
    drain();
  endtask

  task automatic test_glitch();
    for (int n = 1; n <= 15; n++) begin
      BTN = (n <= 3) ? 3'b010 : 3'b000;
      tick();
      checks++;
      if (IRW !== 3'b000 || irq_req !== 1'b0 || m_pend !== 3'b000) begin
        errors++;
        $display("FAIL glitch: tick %0d got req=%0b irw=%b, want req=0 irw=000", n, irq_req, IRW);
      end
    end
  endtask

  task automatic test_priority();
    BTN = 3'b101;
    for (int n = 1; n <= 8; n++) tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd3 || IRW !== 3'b101) begin
      errors++;
      $display("FAIL prio_first: got req=%0b id=%0d irw=%b, want req=1 id=3 irw=101", irq_req, irq_id, IRW);
    end
    BTN = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (irq_req !== 1'b1 || irq_id !== 2'd3) begin
        errors++;
        $display("FAIL prio_stable: tick %0d got req=%0b id=%0d, want req=1 id=3", n, irq_req, irq_id);
      end
    end
    checks++;
    if (IRW !== 3'b111) begin
      errors++;
      $display("FAIL prio_irw: got %b, want 111", IRW);
    end
    for (int k = 3; k >= 2; k--) begin
      ack = 1'b1; ack_id = 2'(k);
      tick();
      ack = 1'b0;
      checks++;
      if (irq_req !== 1'b0 || irq_id !== 2'd0 || IRW !== ((k == 3) ? 3'b011 : 3'b001)) begin
        errors++;
        $display("FAIL prio_gap: ack %0d got req=%0b id=%0d irw=%b", k, irq_req, irq_id, IRW);
      end
      tick();
      tick();
      checks++;
      if (irq_req !== 1'b1 || irq_id !== 2'(k - 1)) begin
        errors++;
        $display("FAIL prio_next: after ack %0d got req=%0b id=%0d, want req=1 id=%0d", k, irq_req, irq_id, k - 1);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int rise_tick [$];
    logic prev_req = 1'b0;
    BTN = 3'b011;
    for (int n = 1; n <= 16; n++) begin
      ack = irq_req; ack_id = irq_id;
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL b2b_model: got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
      if (irq_req && !prev_req) rise_tick.push_back(n);
      prev_req = irq_req;
    end
    ack = 1'b0;
    checks++;
    if (rise_tick.size() != 2 || rise_tick[0] != 8 || rise_tick[1] != 11) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d rises (first %0d), want rises at ticks 8 and 11", rise_tick.size(), (rise_tick.size() > 0) ? rise_tick[0] : -1);
    end
    drain();
  endtask

  task automatic test_wrong_ack();
    logic [1:0] ids [3] = '{2'd1, 2'd3, 2'd0};
    BTN = 3'b010;
    for (int n = 1; n <= 8; n++) tick();
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; ack_id = ids[k];
      tick();
      checks++;
      if (irq_req !== 1'b1 || irq_id !== 2'd2 || IRW !== 3'b010) begin
        errors++;
        $display("FAIL wrong_ack: ack_id=%0d got req=%0b id=%0d irw=%b, want req=1 id=2 irw=010", ids[k], irq_req, irq_id, IRW);
      end
    end
    ack_id = 2'd2;
    tick();
    ack = 1'b0;
    checks++;
    if (irq_req !== 1'b0 || IRW !== 3'b000) begin
      errors++;
      $display("FAIL right_ack: got req=%0b irw=%b, want req=0 irw=000", irq_req, IRW);
    end
    drain();
  endtask

  task automatic test_set_wins();
    BTN = 3'b001;
    for (int n = 1; n <= 8; n++) tick();
    BTN = 3'b000;
    for (int n = 1; n <= 8; n++) tick();
    BTN = 3'b001;
    for (int n = 1; n <= 9; n++) begin
      ack = (n == 7); ack_id = 2'd1;
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL setwins_model: got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
      checks++;
      if ((n <= 6 && (irq_req !== 1'b1 || irq_id !== 2'd1)) ||
          ((n == 7 || n == 8) && (irq_req !== 1'b0 || IRW[0] !== 1'b1)) ||
          (n == 9 && (irq_req !== 1'b1 || irq_id !== 2'd1 || IRW[0] !== 1'b1))) begin
        errors++;
        $display("FAIL setwins_timing: tick %0d got req=%0b id=%0d irw=%b", n, irq_req, irq_id, IRW);
      end
    end
    ack = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(5) == 0) BTN = 3'($urandom_range(7));
      rst = ($urandom_range(150) == 0);
      if (irq_req && $urandom_range(2) == 0) begin
        ack = 1'b1;
        ack_id = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : irq_id;
      end else begin
        ack = ($urandom_range(7) == 0);
        ack_id = 2'($urandom_range(3));
      end
      tick();
      checks++;
      if ({irq_req, irq_id, IRW} !== {m_req, m_id, m_pend}) begin
        errors++;
        $display("FAIL random_model: cycle %0d got req=%0b id=%0d irw=%b, want req=%0b id=%0d irw=%b", c, irq_req, irq_id, IRW, m_req, m_id, m_pend);
      end
    end
    rst = 1'b0; ack = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; BTN = 3'b000; ack = 1'b0; ack_id = 2'd0;
    m_s1 = 3'b000; m_s2 = 3'b000; m_db = 3'b000; m_dbp = 3'b000; m_pend = 3'b000;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_st = 0; m_id = 2'd0; m_req = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_back_to_back();
    test_wrong_ack();
    test_set_wins();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
